// File: rtl/tlb_ptw.sv
// Two-level Sv32-style hardware page-table walker: resolves one TLB miss at a time,
// validates the leaf PTE and writes it into the TLB, or reports a fault/retry.

module tlb_ptw (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic        req_store,
    input  logic [21:0] satp_ppn,
    output logic        mem_req,
    output logic [33:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        tlb_cs,
    output logic        tlb_we,
    output logic [19:0] tlb_vpn,
    output logic        tlb_spage,
    output logic [31:0] tlb_pte,
    input  logic        tlb_flush_req,
    output logic        resp_valid,
    output logic        resp_pf,
    output logic        resp_af,
    output logic        resp_retry
);

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, DRAIN, RESP
    } state_e;

    typedef enum logic [1:0] {
        RESP_OK, RESP_PF, RESP_AF, RESP_RETRY
    } resp_e;

    // PTE flag positions; in this system's page-table layout A sits above D.
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_D = 6;
    localparam int PTE_A = 7;

    state_e      state_q, state_d;
    resp_e       resp_q, resp_d;
    logic [33:0] addr_q, addr_d;
    logic [19:0] vpn_q, vpn_d;
    logic        store_q, store_d;
    logic        spage_q, spage_d;
    logic [31:0] pte_q, pte_d;

    logic pte_invalid;
    logic pte_is_table;
    logic pte_misaligned;
    logic pte_ad_fault;
    logic at_l1;
    logic unused_vaddr_offset;

    assign unused_vaddr_offset = ^req_vaddr[11:0];

    assign at_l1          = (state_q == L1_WAIT);
    assign pte_invalid    = !mem_rdata[PTE_V] || (!mem_rdata[PTE_R] && mem_rdata[PTE_W]);
    assign pte_is_table   = !mem_rdata[PTE_R] && !mem_rdata[PTE_X];
    assign pte_misaligned = at_l1 && (mem_rdata[19:10] != 10'd0);
    assign pte_ad_fault   = !mem_rdata[PTE_A] || (store_q && !mem_rdata[PTE_D]);

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        addr_d  = addr_q;
        vpn_d   = vpn_q;
        store_d = store_q;
        spage_d = spage_q;
        pte_d   = pte_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !tlb_flush_req) begin
                    state_d = L1_REQ;
                    resp_d  = RESP_OK;
                    vpn_d   = req_vaddr[31:12];
                    store_d = req_store;
                    spage_d = 1'b0;
                    addr_d  = {satp_ppn, 12'b0} + {22'b0, req_vaddr[31:22], 2'b0};
                end
            end

            L1_REQ, L0_REQ: begin
                if (tlb_flush_req) begin
                    // A granted read still returns data, which must be swallowed.
                    if (mem_gnt) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RESP;
                        resp_d  = RESP_RETRY;
                    end
                end else if (mem_gnt) begin
                    state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end

            L1_WAIT, L0_WAIT: begin
                if (mem_ack) begin
                    state_d = RESP;
                    if (tlb_flush_req) begin
                        resp_d = RESP_RETRY;
                    end else if (mem_err) begin
                        resp_d = RESP_AF;
                    end else if (pte_invalid) begin
                        resp_d = RESP_PF;
                    end else if (pte_is_table) begin
                        if (at_l1) begin
                            state_d = L0_REQ;
                            addr_d  = {mem_rdata[31:10], 12'b0} + {22'b0, vpn_q[9:0], 2'b0};
                        end else begin
                            resp_d = RESP_PF;
                        end
                    end else if (pte_misaligned || pte_ad_fault) begin
                        resp_d = RESP_PF;
                    end else begin
                        state_d = FILL;
                        pte_d   = mem_rdata;
                        spage_d = at_l1;
                    end
                end else if (tlb_flush_req) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (mem_ack) begin
                    state_d = RESP;
                    resp_d  = RESP_RETRY;
                end
            end

            FILL: begin
                state_d = RESP;
                if (tlb_flush_req) begin
                    resp_d = RESP_RETRY;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            resp_q  <= RESP_OK;
            addr_q  <= '0;
            vpn_q   <= '0;
            store_q <= 1'b0;
            spage_q <= 1'b0;
            pte_q   <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            addr_q  <= addr_d;
            vpn_q   <= vpn_d;
            store_q <= store_d;
            spage_q <= spage_d;
            pte_q   <= pte_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !tlb_flush_req;
    assign mem_req    = (state_q == L1_REQ) || (state_q == L0_REQ);
    assign mem_addr   = addr_q;

    // A flush arriving in FILL wins over the write.
    assign tlb_cs     = (state_q == FILL) && !tlb_flush_req;
    assign tlb_we     = tlb_cs;
    assign tlb_vpn    = vpn_q;
    assign tlb_spage  = spage_q;
    assign tlb_pte    = pte_q;

    assign resp_valid = (state_q == RESP);
    assign resp_pf    = resp_valid && (resp_q == RESP_PF);
    assign resp_af    = resp_valid && (resp_q == RESP_AF);
    assign resp_retry = resp_valid && (resp_q == RESP_RETRY);

endmodule

// File: tb/tb_tlb_ptw.sv
// Self-checking bench for tlb_ptw: directed walks, flush/reset corner cases and
// randomized page tables compared against a behavioural walk model.

module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_store;
    logic [21:0] satp_ppn;
    logic        mem_req;
    logic [33:0] mem_addr;
    logic        mem_gnt;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        tlb_cs;
    logic        tlb_we;
    logic [19:0] tlb_vpn;
    logic        tlb_spage;
    logic [31:0] tlb_pte;
    logic        tlb_flush_req;
    logic        resp_valid;
    logic        resp_pf;
    logic        resp_af;
    logic        resp_retry;

    tlb_ptw dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_store(req_store), .satp_ppn(satp_ppn),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .tlb_cs(tlb_cs), .tlb_we(tlb_we), .tlb_vpn(tlb_vpn), .tlb_spage(tlb_spage),
        .tlb_pte(tlb_pte), .tlb_flush_req(tlb_flush_req),
        .resp_valid(resp_valid), .resp_pf(resp_pf), .resp_af(resp_af), .resp_retry(resp_retry)
    );

    always #5 clk = ~clk;

    localparam int K_OK = 0, K_PF = 1, K_AF = 2, K_RETRY = 3, K_NONE = 4, K_MULTI = 5;

    typedef struct {
        int          kind;
        int          reads;
        int          fills;
        logic [19:0] vpn;
        logic        spage;
        logic [31:0] pte;
        logic [33:0] addr0;
        logic [33:0] addr1;
        int          lat;
        int          cswe_bad;
        logic        ready_after;
    } res_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] pt [logic [33:0]];
    logic [33:0] err_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pt_read(input logic [33:0] a);
        return pt.exists(a) ? pt[a] : 32'h0;
    endfunction

    // Reference: walk the page table with plain arithmetic, one level at a time.
    function automatic res_t walk_model(input logic [31:0] va, input logic st, input logic [21:0] satp);
        res_t        e;
        logic [33:0] a;
        logic [31:0] p;
        e = '{default: 0};
        e.vpn = va[31:12];
        a = 34'(satp) * 34'd4096 + 34'(va[31:22]) * 34'd4;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            if (e.reads == 0) e.addr0 = a; else e.addr1 = a;
            e.reads++;
            if (a == err_addr) begin e.kind = K_AF; return e; end
            p = pt_read(a);
            if (p[0] == 1'b0 || (p[1] == 1'b0 && p[2] == 1'b1)) begin e.kind = K_PF; return e; end
            if (p[1] == 1'b0 && p[3] == 1'b0) begin
                if (lvl == 0) begin e.kind = K_PF; return e; end
                a = 34'(p[31:10]) * 34'd4096 + 34'(va[21:12]) * 34'd4;
                continue;
            end
            if (lvl == 1 && p[19:10] != 10'd0) begin e.kind = K_PF; return e; end
            if (p[7] == 1'b0 || (st && p[6] == 1'b0)) begin e.kind = K_PF; return e; end
            e.kind  = K_OK;
            e.fills = 1;
            e.pte   = p;
            e.spage = (lvl == 1);
            return e;
        end
        return e;
    endfunction

    // Drives one request and plays the memory; gnt_dly/ack_dly < 0 pick random delays.
    task automatic run_walk(input logic [31:0] va, input logic st, input logic [21:0] satp,
                            input int gnt_dly, input int ack_dly, input int flush_it,
                            output res_t r);
        int          acc_it;
        int          ack_at;
        int          wait_g;
        logic        pend;
        logic        done;
        logic [33:0] pend_addr;
        r = '{default: 0};
        r.kind = K_NONE;
        acc_it = -1;
        ack_at = 0;
        pend = 1'b0;
        done = 1'b0;
        pend_addr = '0;
        wait_g = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
        for (int it = 0; it < 300 && !done; it++) begin
            @(negedge clk);
            req_valid = (acc_it < 0);
            req_vaddr = va;
            req_store = st;
            satp_ppn  = satp;
            mem_gnt = 1'b0;
            mem_ack = 1'b0;
            mem_err = 1'b0;
            mem_rdata = $urandom;
            tlb_flush_req = (it == flush_it);
            if (pend && it == ack_at) begin
                mem_ack = 1'b1;
                mem_err = (pend_addr == err_addr);
                mem_rdata = pt_read(pend_addr);
                pend = 1'b0;
            end else if (mem_req) begin
                if (wait_g == 0) mem_gnt = 1'b1;
                else wait_g--;
            end
            #1;
            if (tlb_cs !== tlb_we) r.cswe_bad++;
            if (tlb_we === 1'b1) begin
                r.fills++;
                r.vpn = tlb_vpn;
                r.spage = tlb_spage;
                r.pte = tlb_pte;
            end
            if (resp_valid === 1'b1) begin
                if (int'(resp_pf) + int'(resp_af) + int'(resp_retry) > 1) r.kind = K_MULTI;
                else if (resp_af) r.kind = K_AF;
                else if (resp_pf) r.kind = K_PF;
                else if (resp_retry) r.kind = K_RETRY;
                else r.kind = K_OK;
                r.lat = it - acc_it + 1;
                done = 1'b1;
            end
            if (req_valid && req_ready) acc_it = it;
            if (mem_gnt && mem_req) begin
                if (r.reads == 0) r.addr0 = mem_addr; else r.addr1 = mem_addr;
                r.reads++;
                pend = 1'b1;
                pend_addr = mem_addr;
                ack_at = it + 1 + ((ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly);
                wait_g = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b0;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        tlb_flush_req = 1'b0;
        #1;
        r.ready_after = req_ready;
    endtask

    task automatic check_walk(input string tag, input res_t r, input res_t e);
        chk({tag, ".kind"}, r.kind, e.kind);
        chk({tag, ".reads"}, r.reads, e.reads);
        chk({tag, ".fills"}, r.fills, e.fills);
        if (e.reads > 0) chk({tag, ".addr0"}, r.addr0, e.addr0);
        if (e.reads > 1) chk({tag, ".addr1"}, r.addr1, e.addr1);
        if (e.fills > 0) begin
            chk({tag, ".vpn"}, r.vpn, e.vpn);
            chk({tag, ".spage"}, r.spage, e.spage);
            chk({tag, ".pte"}, r.pte, e.pte);
        end
        chk({tag, ".cs_eq_we"}, r.cswe_bad, 0);
        chk({tag, ".ready_after"}, r.ready_after, 1'b1);
    endtask

    function automatic res_t retry_exp(input int reads, input logic [33:0] a0);
        res_t e;
        e = '{default: 0};
        e.kind = K_RETRY;
        e.reads = reads;
        e.addr0 = a0;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t        r;
        res_t        e;
        logic        quiet;
        logic [31:0] va;
        logic        st;
        logic [21:0] satp;
        logic [21:0] ppn;
        logic [7:0]  fl;
        logic [33:0] l1a;
        logic [33:0] l0a;

        rst = 1'b1;
        req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0; satp_ppn = '0;
        mem_gnt = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        tlb_flush_req = 1'b0;
        err_addr = '1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset.flags", {mem_req, tlb_cs, tlb_we, resp_valid, resp_pf, resp_af, resp_retry, tlb_spage}, 8'h00);
        chk("reset.addr_vpn", {mem_addr, tlb_vpn}, 54'h0);
        chk("reset.pte", tlb_pte, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset.ready", req_ready, 1'b1);

        // Two-level walk with a dirty, accessed leaf on a store.
        pt.delete();
        pt[34'h80004] = 32'h00020401;
        pt[34'h81004] = 32'h048D14C7;
        run_walk(32'h00401234, 1'b1, 22'h00080, 0, 0, -1, r);
        e = walk_model(32'h00401234, 1'b1, 22'h00080);
        check_walk("two_level", r, e);
        chk("two_level.pte_const", r.pte, 32'h048D14C7);
        chk("two_level.addr1_const", r.addr1, 34'h81004);
        chk("two_level.latency", r.lat, 7);

        // L0 PTE without D: store faults, load fills.
        pt[34'h81004] = 32'h048D1487;
        run_walk(32'h00401234, 1'b1, 22'h00080, 0, 1, -1, r);
        chk("no_dirty_store.kind", r.kind, K_PF);
        chk("no_dirty_store.fills", r.fills, 0);
        run_walk(32'h00401234, 1'b0, 22'h00080, 1, 0, -1, r);
        e = walk_model(32'h00401234, 1'b0, 22'h00080);
        check_walk("no_dirty_load", r, e);
        chk("no_dirty_load.kind_const", r.kind, K_OK);

        // Access fault on the second-level read.
        pt[34'h81004] = 32'h048D14C7;
        err_addr = 34'h81004;
        run_walk(32'h00401234, 1'b0, 22'h00080, 0, 0, -1, r);
        e = walk_model(32'h00401234, 1'b0, 22'h00080);
        check_walk("l0_bus_err", r, e);
        chk("l0_bus_err.kind_const", r.kind, K_AF);
        err_addr = '1;

        // Superpage leaf: aligned fills, misaligned faults.
        pt.delete();
        pt[34'h80804] = 32'h001000CF;
        run_walk(32'h80400000, 1'b0, 22'h00080, 0, 0, -1, r);
        e = walk_model(32'h80400000, 1'b0, 22'h00080);
        check_walk("superpage", r, e);
        chk("superpage.spage_const", {r.spage, r.vpn}, {1'b1, 20'h80400});
        chk("superpage.addr0_const", r.addr0, 34'h80804);
        pt[34'h80804] = 32'h001004CF;
        run_walk(32'h80400000, 1'b0, 22'h00080, 0, 0, -1, r);
        chk("superpage_misaligned.kind", r.kind, K_PF);
        chk("superpage_misaligned.fills", r.fills, 0);

        // Flush in L1_WAIT: read drained, retry.
        pt.delete();
        pt[34'h80004] = 32'h00020401;
        pt[34'h81004] = 32'h048D14C7;
        run_walk(32'h00401234, 1'b0, 22'h00080, 0, 2, 2, r);
        check_walk("flush_l1_wait", r, retry_exp(1, 34'h80004));

        // Flush in L1_REQ before any grant.
        run_walk(32'h00401234, 1'b0, 22'h00080, 3, 0, 1, r);
        check_walk("flush_req_no_gnt", r, retry_exp(0, 34'h0));

        // Flush coincident with the grant.
        run_walk(32'h00401234, 1'b0, 22'h00080, 0, 1, 1, r);
        check_walk("flush_with_gnt", r, retry_exp(1, 34'h80004));

        // Flush in FILL suppresses the write.
        pt.delete();
        pt[34'h80804] = 32'h001000CF;
        run_walk(32'h80400000, 1'b0, 22'h00080, 0, 0, 3, r);
        check_walk("flush_fill", r, retry_exp(1, 34'h80804));

        // Flush while idle blocks acceptance.
        @(negedge clk);
        req_valid = 1'b1;
        tlb_flush_req = 1'b1;
        #1;
        chk("flush_idle.ready", req_ready, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        tlb_flush_req = 1'b0;
        #1;
        chk("flush_idle.no_walk", {mem_req, req_ready}, 2'b01);

        // Reset in L0_WAIT abandons the walk; a late ack is ignored.
        pt.delete();
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = 32'h00401234; req_store = 1'b0; satp_ppn = 22'h00080;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rst_walk.l1_req", {mem_req, mem_addr}, {1'b1, 34'h80004});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00020401;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rst_walk.l0_req", {mem_req, mem_addr}, {1'b1, 34'h81004});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_walk.flags", {mem_req, tlb_cs, tlb_we, resp_valid, resp_pf, resp_af, resp_retry, tlb_spage}, 8'h00);
        chk("rst_walk.addr_vpn", {mem_addr, tlb_vpn}, 54'h0);
        chk("rst_walk.pte", tlb_pte, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_walk.ready", req_ready, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h048D14C7;
        @(negedge clk);
        mem_ack = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            #1;
            if (resp_valid !== 1'b0 || tlb_we !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
            @(negedge clk);
        end
        chk("rst_walk.late_ack_ignored", quiet, 1'b1);

        // Randomized page tables and memory timing.
        for (int t = 0; t < 40; t++) begin
            pt.delete();
            satp = 22'($urandom);
            va = $urandom;
            st = 1'($urandom);
            l1a = {satp, 12'b0} + {22'b0, va[31:22], 2'b0};
            l0a = '1;
            case ($urandom_range(0, 2))
                0: begin
                    ppn = 22'($urandom);
                    fl = 8'($urandom);
                    fl[3:0] = 4'b0001;
                    pt[l1a] = {ppn, 2'b00, fl};
                    l0a = {ppn, 12'b0} + {22'b0, va[21:12], 2'b0};
                    fl = 8'($urandom);
                    fl[0] = ($urandom_range(0, 5) != 0);
                    fl[1] = ($urandom_range(0, 3) != 0);
                    fl[7] = ($urandom_range(0, 3) != 0);
                    pt[l0a] = {22'($urandom), 2'b00, fl};
                end
                1: begin
                    ppn = 22'($urandom);
                    if ($urandom_range(0, 1) == 0) ppn[9:0] = 10'd0;
                    fl = 8'($urandom);
                    fl[1:0] = 2'b11;
                    pt[l1a] = {ppn, 2'b00, fl};
                end
                default: pt[l1a] = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: err_addr = l1a;
                1: err_addr = l0a;
                default: err_addr = '1;
            endcase
            e = walk_model(va, st, satp);
            run_walk(va, st, satp, -1, -1, -1, r);
            check_walk($sformatf("rand%0d", t), r, e);
        end
        err_addr = '1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_ptw.md
TLB_PTW -- requirements
Module: tlb_ptw

Interface
REQ-001 clk  in  1  single clock; all flops rise-edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 req_valid  in  1  requester has a TLB miss to resolve.
REQ-004 req_ready  out  1  walker accepts request (high only in IDLE with tlb_flush_req low).
REQ-005 req_vaddr  in  32  virtual address, sampled on req_valid&req_ready.
REQ-006 req_store  in  1  access is a store, sampled with req_vaddr.
REQ-007 satp_ppn  in  22  root page-table PPN, sampled with req_vaddr.
REQ-008 mem_req  out  1  PTE read request, held until mem_gnt.
REQ-009 mem_addr  out  34  PTE physical address, stable while mem_req high.
REQ-010 mem_gnt  in  1  memory accepts request.
REQ-011 mem_ack  in  1  read data valid; never in the same cycle as mem_gnt.
REQ-012 mem_rdata  in  32  PTE data, valid with mem_ack.
REQ-013 mem_err  in  1  bus error, valid with mem_ack.
REQ-014 tlb_cs, tlb_we  out  1 each  TLB fill strobes, both high together for exactly one cycle.
REQ-015 tlb_vpn  out  20  fill VPN (req_vaddr[31:12]).
REQ-016 tlb_spage  out  1  fill is a 4 MiB superpage.
REQ-017 tlb_pte  out  32  leaf PTE written to the TLB.
REQ-018 tlb_flush_req  in  1  TLB flush; aborts any walk.
REQ-019 resp_valid  out  1  one-cycle completion pulse.
REQ-020 resp_pf, resp_af, resp_retry  out  1 each  page fault / access fault / aborted-retry, valid with resp_valid, mutually exclusive.

Function
REQ-021 The FSM SHALL have states IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, DRAIN, RESP.
REQ-022 Accept: IDLE -> L1_REQ; mem_addr = {satp_ppn,12'b0} + {vpn1,2'b0}.
REQ-023 x_REQ -> x_WAIT on mem_gnt; x_WAIT holds until mem_ack.
REQ-024 On mem_ack with mem_err=1: resp_af=1, -> RESP, no TLB write.
REQ-025 PTE invalid (V=0, or R=0 & W=1): resp_pf=1, -> RESP.
REQ-026 Non-leaf (R=0 & X=0) at L1: mem_addr = {pte[31:10],12'b0} + {vpn0,2'b0}, -> L0_REQ; non-leaf at L0: resp_pf=1.
REQ-027 Leaf at L1 with pte[19:10] != 0 (misaligned superpage): resp_pf=1; otherwise tlb_spage=1.
REQ-028 Leaf with A=0, or req_store=1 & D=0: resp_pf=1 (no hardware A/D update).
REQ-029 Good leaf: -> FILL; in FILL, tlb_cs=tlb_we=1 with registered vpn/spage/pte; FILL -> RESP.
REQ-030 RESP: resp_valid=1 for one cycle, -> IDLE; earliest next accept is the cycle after RESP.
REQ-031 Minimum latency, 2-level walk with gnt and ack each 1 cycle after request: accept to resp_valid = 7 cycles.
REQ-032 tlb_flush_req in any *_REQ state whose mem_gnt is low that cycle: drop mem_req, resp_retry=1, -> RESP.
REQ-033 tlb_flush_req in *_WAIT, or in *_REQ coincident with mem_gnt: -> DRAIN; DRAIN consumes and discards mem_ack, then resp_retry=1 -> RESP.
REQ-034 tlb_flush_req in FILL: suppress tlb_cs/tlb_we, resp_retry=1; flush has priority over fill.
REQ-035 tlb_flush_req in IDLE: req_ready=0, no state change.
REQ-036 All mem_addr arithmetic SHALL be 34-bit unsigned.

Reset
REQ-037 On rst: state=IDLE; mem_req, tlb_cs, tlb_we, resp_valid, resp_pf, resp_af, resp_retry, tlb_spage = 0; mem_addr, tlb_vpn, tlb_pte = 0; req_ready = 1 on the first cycle after release.
REQ-038 rst mid-walk SHALL abandon the walk; a mem_ack arriving after reset release SHALL be ignored in IDLE.

Verification
REQ-039 satp_ppn=0x00080, vaddr=0x00401234, store; L1@0x80004 returns 0x00020401, L0@0x81004 returns 0x048D14C7 -> one fill: vpn=0x00401, spage=0, pte=0x048D14C7; resp_valid with no fault bits set.
REQ-040 vaddr=0x80400000; L1@0x80804 returns 0x001000CF -> one mem read, fill with spage=1, vpn=0x80400.
REQ-041 Same as REQ-040 but returns 0x001004CF -> resp_pf=1, tlb_we never asserted.
REQ-042 L0 returns 0x048D1487 (D=0) with req_store=1 -> resp_pf=1; same PTE with req_store=0 -> fill.
REQ-043 tlb_flush_req pulsed in L1_WAIT -> mem_ack discarded in DRAIN, resp_retry=1, no fill, req_ready=1 next cycle.
REQ-044 mem_ack with mem_err=1 at L0 -> resp_af=1, no fill; rst asserted in L0_WAIT -> all outputs 0, later mem_ack ignored.
